// File: rtl/apb_initiator_pkg.sv
// Shared types and constants for the APB3 initiator slice.
package apb_initiator_pkg;

   localparam int APB_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_init_state_e;

   // Plain-vector aliases of the state encoding for legacy-compatible state registers
   localparam logic [1:0] ST_IDLE   = IDLE;
   localparam logic [1:0] ST_SETUP  = SETUP;
   localparam logic [1:0] ST_ACCESS = ACCESS;
   localparam logic [1:0] ST_RESP   = RESP;

endpackage

// File: rtl/apb_initiator_if.sv
// APB3 bus bundle between the initiator (master) and a peripheral (slave).
interface apb_initiator_if #(
   parameter int ADDR_WIDTH = 12
) ();
   import apb_initiator_pkg::*;

   logic [ADDR_WIDTH-1:0]     PADDR;
   logic [APB_DATA_WIDTH-1:0] PWDATA;
   logic                      PWRITE;
   logic                      PSEL;
   logic                      PENABLE;
   logic [APB_DATA_WIDTH-1:0] PRDATA;
   logic                      PREADY;
   logic                      PSLVERR;

   modport master (
      output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
      input  PRDATA, PREADY, PSLVERR
   );

   modport slave (
      input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
      output PRDATA, PREADY, PSLVERR
   );

endinterface

// File: rtl/apb_initiator_timeout_cnt.sv
// ACCESS-phase wait counter; flags the cycle in which the LIMIT-th wait state occurs.
module apb_timeout_cnt #(
   parameter int LIMIT = 256
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
   localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

   logic [CW-1:0] cnt_r;
   logic          hit_s;

   // A zero limit disables the timeout entirely
   always_comb begin
      hit_s = 1'b0;
      if ((LIMIT != 0) && enable && (cnt_r == LAST)) begin
         hit_s = 1'b1;
      end else begin
         hit_s = 1'b0;
      end
   end

   assign expired = hit_s;

   // Wait-state counter, cleared when a new command is accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CW{1'b0}};
      end else if (clear) begin
         cnt_r <= {CW{1'b0}};
      end else if (enable && !hit_s) begin
         cnt_r <= cnt_r + CW'(1);
      end
   end

endmodule

// File: rtl/apb_initiator.sv
// APB3 requester: one outstanding single-word command, bounded ACCESS wait.
module apb_initiator
   import apb_initiator_pkg::*;
#(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                      HCLK,
   input  logic                      HRESETn,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
   input  logic                      req_write_i,
   input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic                      rsp_tout_o,
   apb_initiator_if.master           apb
);

   logic [1:0] state_r;
   logic       accept_s;
   logic       wait_s;
   logic       expired_s;

   // Command acceptance and wait-state qualification
   always_comb begin
      accept_s = 1'b0;
      wait_s   = 1'b0;
      if (state_r == ST_IDLE) begin
         accept_s = req_valid_i;
      end else begin
         accept_s = 1'b0;
      end
      if (state_r == ST_ACCESS) begin
         wait_s = !apb.PREADY;
      end else begin
         wait_s = 1'b0;
      end
   end

   apb_timeout_cnt #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (HCLK),
      .rst_n   (HRESETn),
      .clear   (accept_s),
      .enable  (wait_s),
      .expired (expired_s)
   );

   // Transfer FSM; every output is a register
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_r     <= ST_IDLE;
         req_ready_o <= 1'b1;
         rsp_valid_o <= 1'b0;
         rsp_rdata_o <= {APB_DATA_WIDTH{1'b0}};
         rsp_err_o   <= 1'b0;
         rsp_tout_o  <= 1'b0;
         apb.PADDR   <= {APB_ADDR_WIDTH{1'b0}};
         apb.PWDATA  <= {APB_DATA_WIDTH{1'b0}};
         apb.PWRITE  <= 1'b0;
         apb.PSEL    <= 1'b0;
         apb.PENABLE <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  apb.PADDR   <= req_addr_i;
                  apb.PWRITE  <= req_write_i;
                  apb.PWDATA  <= req_wdata_i;
                  apb.PSEL    <= 1'b1;
                  req_ready_o <= 1'b0;
                  state_r     <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               apb.PENABLE <= 1'b1;
               state_r     <= ST_ACCESS;
            end
            ST_ACCESS: begin
               // A PREADY on the limit cycle still completes normally
               if (apb.PREADY) begin
                  rsp_rdata_o <= apb.PWRITE ? {APB_DATA_WIDTH{1'b0}} : apb.PRDATA;
                  rsp_err_o   <= apb.PSLVERR;
                  rsp_tout_o  <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  apb.PSEL    <= 1'b0;
                  apb.PENABLE <= 1'b0;
                  state_r     <= ST_RESP;
               end else if (expired_s) begin
                  rsp_rdata_o <= {APB_DATA_WIDTH{1'b0}};
                  rsp_err_o   <= 1'b1;
                  rsp_tout_o  <= 1'b1;
                  rsp_valid_o <= 1'b1;
                  apb.PSEL    <= 1'b0;
                  apb.PENABLE <= 1'b0;
                  state_r     <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  req_ready_o <= 1'b1;
                  state_r     <= ST_IDLE;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               req_ready_o <= 1'b1;
               rsp_valid_o <= 1'b0;
               apb.PSEL    <= 1'b0;
               apb.PENABLE <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_initiator.sv
// Scoreboard bench: scripted APB slave, randomized commands and response back-pressure.
module tb_apb_initiator;

   localparam int TOUT = 4;

   typedef struct {
      logic [11:0] addr;
      logic        wr;
      logic [31:0] wdata;
      int          wt;
      logic        err;
      logic [31:0] rdata;
      int          acc_cyc;
   } txn_t;

   logic        HCLK;
   logic        HRESETn;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [11:0] req_addr_i;
   logic        req_write_i;
   logic [31:0] req_wdata_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        rsp_tout_o;

   int   cyc = 0;
   int   n_checks = 0;
   int   n_err = 0;
   int   rdy_mode = 1;
   txn_t slave_q[$];
   txn_t sb_q[$];

   apb_initiator_if #(.ADDR_WIDTH(12)) apb ();

   apb_initiator #(
      .APB_ADDR_WIDTH (12),
      .TIMEOUT_CYCLES (TOUT)
   ) dut (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_addr_i  (req_addr_i),
      .req_write_i (req_write_i),
      .req_wdata_i (req_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .rsp_tout_o  (rsp_tout_o),
      .apb         (apb)
   );

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   always @(posedge HCLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: how many ACCESS cycles a command occupies
   function automatic int exp_len(input txn_t t);
      return (t.wt >= TOUT) ? TOUT : t.wt + 1;
   endfunction

   // Reference model: {tout, err, rdata} of the response
   function automatic logic [33:0] exp_word(input txn_t t);
      if (t.wt >= TOUT) return {2'b11, 32'h0};
      return {1'b0, t.err, (t.wr ? 32'h0 : t.rdata)};
   endfunction

   function automatic txn_t mk(input logic [11:0] a, input logic w, input logic [31:0] d,
                               input int wt, input logic e, input logic [31:0] r);
      txn_t t;
      t.addr = a; t.wr = w; t.wdata = d; t.wt = wt; t.err = e; t.rdata = r; t.acc_cyc = 0;
      return t;
   endfunction

   // Present a command, hold it until accepted, then record it for slave and scoreboard
   task automatic issue(input txn_t t_in, input bit expect_rsp);
      txn_t t;
      int   g;
      t = t_in;
      g = 0;
      req_valid_i = 1'b1;
      req_addr_i  = t.addr;
      req_write_i = t.wr;
      req_wdata_i = t.wdata;
      while (!req_ready_o && g < 200) begin
         @(negedge HCLK);
         g++;
      end
      chk("accept_timeout", 64'(g >= 200), 64'd0);
      t.acc_cyc = cyc;
      slave_q.push_back(t);
      if (expect_rsp) sb_q.push_back(t);
      @(negedge HCLK);
      req_valid_i = 1'b0;
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (sb_q.size() != 0 && g < 400) begin
         @(negedge HCLK);
         g++;
      end
      chk("drain", 64'(sb_q.size()), 64'd0);
      @(negedge HCLK);
   endtask

   // Response back-pressure: 0 random, 1 always ready, 2 stalled
   initial begin
      rsp_ready_i = 1'b1;
      forever begin
         @(posedge HCLK);
         #1;
         case (rdy_mode)
            1:       rsp_ready_i = 1'b1;
            2:       rsp_ready_i = 1'b0;
            default: rsp_ready_i = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // APB slave model with scripted wait states; checks phase timing and bus stability
   initial begin
      txn_t cur;
      int   k;
      bit   busy;
      apb.PREADY  = 1'b0;
      apb.PRDATA  = 32'h0;
      apb.PSLVERR = 1'b0;
      busy = 1'b0;
      k    = 0;
      forever begin
         @(negedge HCLK);
         if (!HRESETn) begin
            busy = 1'b0;
            apb.PREADY = 1'b0;
         end else if (apb.PSEL && !apb.PENABLE) begin
            apb.PREADY = 1'b0;
            chk("setup_expected", 64'(slave_q.size()), 64'd1);
            if (slave_q.size() != 0) begin
               cur  = slave_q.pop_front();
               busy = 1'b1;
               k    = 0;
               chk("setup_cycle", 64'(cyc), 64'(cur.acc_cyc + 1));
               chk("setup_bus", {apb.PWRITE, apb.PADDR, apb.PWDATA}, {cur.wr, cur.addr, cur.wdata});
            end
         end else if (apb.PSEL && apb.PENABLE && busy) begin
            k++;
            chk("access_bus", {apb.PWRITE, apb.PADDR, apb.PWDATA}, {cur.wr, cur.addr, cur.wdata});
            if (k == cur.wt + 1) begin
               apb.PREADY  = 1'b1;
               apb.PRDATA  = cur.rdata;
               apb.PSLVERR = cur.err;
            end else begin
               apb.PREADY  = 1'b0;
               apb.PRDATA  = $urandom;
               apb.PSLVERR = 1'($urandom_range(0, 1));
            end
         end else begin
            if (busy) chk("access_len", 64'(k), 64'(exp_len(cur)));
            busy = 1'b0;
            apb.PREADY = 1'b0;
         end
      end
   end

   // Response monitor: pops the scoreboard on each handshake
   initial begin
      txn_t        e;
      logic [33:0] held;
      logic [33:0] now_w;
      bit          pend;
      pend = 1'b0;
      held = 34'h0;
      forever begin
         @(negedge HCLK);
         if (!HRESETn) begin
            pend = 1'b0;
         end else if (rsp_valid_o) begin
            now_w = {rsp_tout_o, rsp_err_o, rsp_rdata_o};
            chk("req_ready_in_resp", 64'(req_ready_o), 64'd0);
            if (!pend) begin
               chk("rsp_expected", 64'(sb_q.size()), 64'd1);
               if (sb_q.size() != 0) begin
                  e = sb_q[0];
                  chk("rsp_latency", 64'(cyc), 64'(e.acc_cyc + 2 + exp_len(e)));
                  chk("rsp_value", 64'(now_w), 64'(exp_word(e)));
               end
            end else begin
               chk("rsp_stable", 64'(now_w), 64'(held));
            end
            held = now_w;
            pend = !rsp_ready_i;
            if (rsp_ready_i && sb_q.size() != 0) void'(sb_q.pop_front());
         end else begin
            pend = 1'b0;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      txn_t b;
      txn_t r;
      HRESETn     = 1'b0;
      req_valid_i = 1'b0;
      req_addr_i  = 12'h0;
      req_write_i = 1'b0;
      req_wdata_i = 32'h0;
      repeat (2) @(negedge HCLK);
      chk("reset_ctrl", {req_ready_o, rsp_valid_o, rsp_err_o, rsp_tout_o, apb.PSEL, apb.PENABLE, apb.PWRITE},
          64'b1000000);
      chk("reset_data", {rsp_rdata_o, apb.PWDATA}, 64'h0);
      chk("reset_addr", 64'(apb.PADDR), 64'h0);
      HRESETn = 1'b1;
      @(negedge HCLK);

      // Directed: zero-wait write, 3-wait read on the limit cycle, slave error, timeout
      rdy_mode = 1;
      issue(mk(12'h004, 1'b1, 32'hFFFF_FF00, 0, 1'b0, 32'hCAFE_0001), 1'b1);
      issue(mk(12'h008, 1'b0, 32'h0, 3, 1'b0, 32'h0000_1234), 1'b1);
      issue(mk(12'h00C, 1'b0, 32'h0, 1, 1'b1, 32'hDEAD_BEEF), 1'b1);
      issue(mk(12'h000, 1'b1, 32'h0000_0005, 0, 1'b0, 32'h0), 1'b1);
      issue(mk(12'h008, 1'b0, 32'h0, 10, 1'b0, 32'h7777_7777), 1'b1);
      drain();

      // Response stalled while the next command is already waiting
      rdy_mode = 2;
      issue(mk(12'h010, 1'b0, 32'h0, 0, 1'b0, 32'hA5A5_5A5A), 1'b1);
      b = mk(12'h014, 1'b1, 32'h1357_9BDF, 2, 1'b0, 32'h0);
      req_valid_i = 1'b1;
      req_addr_i  = b.addr;
      req_write_i = b.wr;
      req_wdata_i = b.wdata;
      repeat (8) @(negedge HCLK);
      rdy_mode = 1;
      issue(b, 1'b1);
      drain();

      // Randomized commands with random back-pressure
      rdy_mode = 0;
      for (int i = 0; i < 40; i++) begin
         r = mk(12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)), $urandom,
                int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), $urandom);
         issue(r, 1'b1);
      end
      drain();

      // Asynchronous reset in the middle of ACCESS
      rdy_mode = 1;
      issue(mk(12'h008, 1'b0, 32'h0, 20, 1'b0, 32'h1), 1'b0);
      @(posedge HCLK);
      #2;
      chk("pre_reset_access", {apb.PSEL, apb.PENABLE}, 64'b11);
      HRESETn = 1'b0;
      #1;
      chk("reset_async_drop", {apb.PSEL, apb.PENABLE, rsp_valid_o}, 64'b000);
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b1;
      @(negedge HCLK);
      chk("post_reset_ctrl", {req_ready_o, rsp_valid_o, apb.PSEL, apb.PENABLE}, 64'b1000);
      chk("post_reset_addr", 64'(apb.PADDR), 64'h0);
      repeat (10) @(negedge HCLK);
      chk("queues_empty", 64'(sb_q.size() + slave_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
